// File: rtl/loong_uart_tx_framer_if.sv
// Handshake bundle between the LOONG core side and the UART return-path framer.
interface loong_uart_tx_framer_if;
    logic        start;
    logic [63:0] ciphertext_flat;
    logic        tx_serial;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output ciphertext_flat,
        input  tx_serial,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  ciphertext_flat,
        output tx_serial,
        output busy,
        output done
    );
endinterface

// File: rtl/loong_uart_tx_framer.sv
// Serializes a captured 16-nibble ciphertext as an 18-byte 8N1 UART frame:
// header, one byte per nibble (nibble 0 first), trailer.
module loong_uart_tx_framer #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  HEADER_BYTE  = 8'hAA,
    parameter logic [7:0]  TRAILER_BYTE = 8'hFF
) (
    input  logic                   clck,
    input  logic                   reset,
    loong_uart_tx_framer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        DONE
    } state_t;

    localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]     LAST_BYTE = 5'd17;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [4:0]     byte_idx_q, byte_idx_d;
    logic [63:0]    cipher_q, cipher_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [7:0]     cur_byte;

    function automatic logic [7:0] frame_byte(input logic [4:0] idx, input logic [63:0] data);
        logic [3:0] nib_idx;
        logic [3:0] nib;
        nib_idx = 4'(idx - 5'd1);
        nib     = data[{nib_idx, 2'b00} +: 4];
        if (idx == 5'd0)
            return HEADER_BYTE;
        else if (idx == LAST_BYTE)
            return TRAILER_BYTE;
        else
            return {4'h0, nib};
    endfunction

    // tx_d always carries the level for the cycle after the edge, so the line
    // changes exactly on bit boundaries with no gap between stop and next start.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        cipher_d   = cipher_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cur_byte   = frame_byte(byte_idx_q, cipher_q);

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.start) begin
                    cipher_d   = bus.ciphertext_flat;
                    byte_idx_d = 5'd0;
                    bit_idx_d  = 3'd0;
                    cnt_d      = '0;
                    state_d    = START_BIT;
                    busy_d     = 1'b1;
                    tx_d       = 1'b0;
                end
            end
            START_BIT: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA_BITS;
                    tx_d      = cur_byte[0];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA_BITS: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP_BIT;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = cur_byte[bit_idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP_BIT: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (byte_idx_q < LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 5'd1;
                        state_d    = START_BIT;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clck) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 5'd0;
            cipher_q   <= 64'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            cipher_q   <= cipher_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.tx_serial = tx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_loong_uart_tx_framer.sv
// Bench for loong_uart_tx_framer: cycle-level waveform model, mid-bit receiver
// and literal frame expectations.
module tb_loong_uart_tx_framer;

    localparam int CPB   = 4;
    localparam int BYTE_CYC = 10 * CPB;
    localparam int FRAME = 18 * BYTE_CYC;

    logic clck = 1'b0;
    logic reset;

    loong_uart_tx_framer_if bus ();

    loong_uart_tx_framer #(
        .CLKS_PER_BIT (CPB),
        .HEADER_BYTE  (8'hAA),
        .TRAILER_BYTE (8'hFF)
    ) dut (
        .clck  (clck),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clck = ~clck;

    int total = 0;
    int bad   = 0;

    int         m_pos = -1;
    logic [7:0] m_bytes [18];
    int         done_seen = 0;
    int         cyc = 0;
    int         first_low = -1;
    int         done_cyc = -1;
    logic       tx_prev = 1'b1;

    int         rx_cnt = 0;
    bit         rx_on = 1'b0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rxq [$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic build_frame(input logic [63:0] ct, output logic [7:0] fr [18]);
        fr[0]  = 8'hAA;
        fr[17] = 8'hFF;
        for (int i = 1; i <= 16; i++)
            fr[i] = 8'((ct >> (4 * (i - 1))) & 64'hF);
    endtask

    // Reference: position within the frame decides the line level by arithmetic alone.
    always begin
        logic exp_tx, exp_busy, exp_done;
        int   b, p;
        @(posedge clck);
        cyc++;
        if (reset)
            m_pos = -1;
        else if (m_pos == -1) begin
            if (bus.start === 1'b1) begin
                build_frame(bus.ciphertext_flat, m_bytes);
                m_pos = 0;
            end
        end else if (m_pos == FRAME)
            m_pos = -1;
        else
            m_pos++;
        #1;
        if (m_pos == -1) begin
            exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
        end else if (m_pos == FRAME) begin
            exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b1;
        end else begin
            b = m_pos / BYTE_CYC;
            p = (m_pos % BYTE_CYC) / CPB;
            if (p == 0)      exp_tx = 1'b0;
            else if (p == 9) exp_tx = 1'b1;
            else             exp_tx = m_bytes[b][p-1];
            exp_busy = 1'b1; exp_done = 1'b0;
        end
        checkOutput("tx_serial", 64'(bus.tx_serial), 64'(exp_tx));
        checkOutput("busy",      64'(bus.busy),      64'(exp_busy));
        checkOutput("done",      64'(bus.done),      64'(exp_done));
        if (bus.done === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
        end
        if (tx_prev === 1'b1 && bus.tx_serial === 1'b0 && first_low < 0)
            first_low = cyc;
        tx_prev = bus.tx_serial;
    end

    // Independent receiver sampling each bit at its midpoint.
    always begin
        int j;
        @(posedge clck);
        #2;
        if (reset)
            rx_on = 1'b0;
        else if (!rx_on) begin
            if (bus.tx_serial === 1'b0) begin
                rx_on  = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                j = rx_cnt / CPB;
                if (j == 0)
                    checkOutput("rx_start_bit", 64'(bus.tx_serial), 64'd0);
                else if (j <= 8)
                    rx_sh[j-1] = bus.tx_serial;
                else begin
                    checkOutput("rx_stop_bit", 64'(bus.tx_serial), 64'd1);
                    rxq.push_back(rx_sh);
                    rx_on = 1'b0;
                end
            end
        end
    end

    task automatic clear_tracking();
        rxq.delete();
        first_low = -1;
        done_cyc  = -1;
        done_seen = 0;
    endtask

    task automatic applyStimulus(input logic [63:0] ct);
        clear_tracking();
        bus.ciphertext_flat = ct;
        bus.start = 1'b1;
        @(negedge clck);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clck);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen)
            checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_frame(input string name, input logic [7:0] exp [18]);
        checkOutput({name, "_len"}, 64'(rxq.size()), 64'd18);
        for (int i = 0; i < 18; i++)
            if (i < rxq.size())
                checkOutput($sformatf("%s_byte%0d", name, i), 64'(rxq[i]), 64'(exp[i]));
    endtask

    initial begin
        logic [7:0] fr [18];
        logic [7:0] lit1 [18];
        logic [7:0] lit2 [18];
        lit1 = '{8'hAA, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'hFF};
        lit2 = '{8'hAA, 8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h09, 8'h08,
                 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'hFF};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.ciphertext_flat = 64'd0;
        repeat (3) @(negedge clck);
        reset = 1'b0;
        repeat (10) @(negedge clck);
        checkOutput("idle_done_count", 64'(done_seen), 64'd0);

        $display("[TB] basic frame");
        applyStimulus(64'hFEDCBA9876543210);
        wait_done(FRAME + 20);
        checkOutput("done_latency", 64'(done_cyc - first_low), 64'(FRAME));
        check_frame("frame1", lit1);

        $display("[TB] restart ignored, input change ignored");
        repeat (3) @(negedge clck);
        applyStimulus(64'h0123456789ABCDEF);
        bus.ciphertext_flat = '1;
        repeat (100) @(negedge clck);
        bus.start = 1'b1;
        @(negedge clck);
        bus.start = 1'b0;
        wait_done(FRAME + 20);
        repeat (5) @(negedge clck);
        check_frame("frame2", lit2);
        checkOutput("single_done", 64'(done_seen), 64'd1);

        $display("[TB] reset abort in byte 5");
        applyStimulus(64'h1122334455667788);
        repeat (5 * BYTE_CYC + 10) @(negedge clck);
        reset = 1'b1;
        @(negedge clck);
        reset = 1'b0;
        checkOutput("abort_tx", 64'(bus.tx_serial), 64'd1);
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        repeat (60) @(negedge clck);
        checkOutput("abort_no_done", 64'(done_seen), 64'd0);
        applyStimulus(64'h1122334455667788);
        wait_done(FRAME + 20);
        build_frame(64'h1122334455667788, fr);
        check_frame("frame3", fr);

        $display("[TB] start in done cycle");
        clear_tracking();
        bus.ciphertext_flat = 64'h5A5A5A5A5A5A5A5A;
        bus.start = 1'b1;
        @(negedge clck);
        checkOutput("done_cycle_start_ignored", 64'(bus.busy), 64'd0);
        @(negedge clck);
        bus.start = 1'b0;
        checkOutput("next_cycle_accepted", 64'(bus.busy), 64'd1);
        wait_done(FRAME + 20);
        build_frame(64'h5A5A5A5A5A5A5A5A, fr);
        check_frame("frame4", fr);
        checkOutput("frame4_header", 64'(rxq.size() > 0 ? rxq[0] : 8'h00), 64'hAA);

        repeat (5) @(negedge clck);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/loong_uart_tx_framer.md
Name: loong_uart_tx_framer

Overview:
Return-path framer for the LOONG encryption core. It captures the 16 ciphertext nibbles when the core signals completion and serializes them on the board UART TX line. The frame layout mirrors the inbound command frame: header byte, 16 data bytes, trailer byte. The block contains its own bit-level UART transmitter (8N1) and sits beside the LOONG top, driving the host-facing TX pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (434 = 115200 baud at 50 MHz); legal range 2 or more.
HEADER_BYTE, 8'hAA, first byte of every frame.
TRAILER_BYTE, 8'hFF, last byte of every frame.

Ports:
clck  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle request to send a frame.
ciphertext_flat  input  64  ciphertext nibbles; nibble i is at bits [4i+3:4i], i = 0..15.
tx_serial  output  1  UART TX line; idles high.
busy  output  1  high from the cycle after start is accepted until the frame completes.
done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset values (on the clock edge where reset=1): tx_serial=1, busy=0, done=0, FSM=IDLE, all counters 0.
- Reset has priority over all other inputs. A reset during a frame aborts it: tx_serial is 1 on the next cycle, no done pulse is issued, and no partial byte is resumed.
- Frame order is byte 0 = HEADER_BYTE, bytes 1..16 = {4'h0, ciphertext[i-1]} (i = 1..16, nibble 0 first), byte 17 = TRAILER_BYTE.
- The 64-bit ciphertext_flat is registered on the accept cycle. Changes to the input after that cycle do not affect the frame in flight.
- Byte format is 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1). Each bit is held for exactly CLKS_PER_BIT cycles.
- Bytes are sent back-to-back: the next start bit begins on the cycle after the previous stop bit ends, with no idle gap.
- FSM states:
  - IDLE: on start=1, capture data, set byte index 0, go to START_BIT. busy=1 and tx_serial=0 from the next cycle.
  - START_BIT: drive 0 for CLKS_PER_BIT cycles, then go to DATA_BITS.
  - DATA_BITS: drive the current bit, advancing every CLKS_PER_BIT cycles; after bit 7, go to STOP_BIT.
  - STOP_BIT: drive 1 for CLKS_PER_BIT cycles. If byte index < 17: increment it and go to START_BIT. Otherwise go to DONE.
  - DONE: done=1 and busy=0 for this single cycle, tx_serial=1, then go to IDLE.
- Latency: total frame time from the first start-bit cycle to the last stop-bit cycle is 18 × 10 × CLKS_PER_BIT cycles. done asserts on the cycle immediately after that.
- start while busy=1 (any state except IDLE) is ignored and is not queued.
- start asserted in the DONE cycle is also ignored. A new frame can be accepted from the first IDLE cycle onward.
- Counter widths: the bit-period counter is sized with $clog2(CLKS_PER_BIT) and wraps to 0 at CLKS_PER_BIT-1. The bit index is 3 bits and the byte index is 5 bits. No counter may overflow for any legal parameter value.
- done and busy are never high in the same cycle.

Test Plan:
- CLKS_PER_BIT=4, reset held 3 cycles then released -> tx_serial=1, busy=0, done=0 throughout; no activity with start=0.
- ciphertext_flat=64'hFEDCBA9876543210, start pulse -> line decodes as AA 00 01 02 … 0F FF; done pulses exactly 720 cycles after the first start bit; busy high for all 720 cycles.
- Each bit is sampled at mid-period by a reference receiver model -> every start bit reads 0, every stop bit reads 1, and no idle gap exists between bytes (checked by an edge-timing monitor).
- Second start pulse mid-frame, and ciphertext_flat changed to all 1s after the accept cycle -> the frame still carries the original nibbles, and exactly one done pulse is issued.
- reset pulsed during byte 5 -> tx_serial=1 and busy=0 on the next cycle, no done pulse; a fresh start then sends a complete, correct 18-byte frame.
- start asserted in the DONE cycle -> ignored; start on the following cycle -> accepted, and the frame begins with AA.
